// File: rtl/me_frame_ctrl.sv
// me_frame_ctrl
// ---------------------------------------------------------------------------
// Frame-level sequencer for the `me` motion-estimation core. It walks the
// frame in raster order, one macroblock at a time. For each macroblock it:
//   1. asks the loader to fill the BRAMs (LOAD),
//   2. waits for `me` to be idle and fires a one-cycle start (ARM),
//   3. waits for the result under a watchdog (RUN),
//   4. presents the centred, signed result on a valid/ready port (OUT).
// It also keeps a saturating per-frame SAD total and a sticky timeout flag.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   frame_start         begins a frame; honoured only while idle
//   busy                high whenever the sequencer is not idle
//   frame_done          one-cycle pulse after the last result is accepted
//   load_req            loader request for (load_mb_x, load_mb_y)
//   load_mb_x/_y        macroblock coordinates being processed
//   load_done           loader finished (sampled only in LOAD)
//   me_start            one-cycle start pulse to `me`
//   me_ready            `me` is idle
//   me_valid            `me` result valid (sampled only in RUN)
//   me_mv_x/_y          unsigned search offsets, 0..SEARCH_DIM-MACRO_DIM
//   me_min_sad          minimum SAD from `me`
//   res_valid/res_ready result handshake
//   res_mb_x/_y         macroblock coordinates of the result
//   res_mv_x/_y         signed two's-complement motion vector, centred
//   res_sad             SAD of the result (16'hFFFF on timeout)
//   frame_sad           saturating sum of accepted res_sad for the frame
//   err_timeout         sticky; some macroblock of this frame timed out
// All outputs are registered.
// ---------------------------------------------------------------------------
module me_frame_ctrl #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48,
    parameter int FRAME_W_MB = 4,
    parameter int FRAME_H_MB = 3,
    parameter int TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    output logic        busy,
    output logic        frame_done,
    output logic        load_req,
    output logic [7:0]  load_mb_x,
    output logic [7:0]  load_mb_y,
    input  logic        load_done,
    output logic        me_start,
    input  logic        me_ready,
    input  logic        me_valid,
    input  logic [5:0]  me_mv_x,
    input  logic [5:0]  me_mv_y,
    input  logic [15:0] me_min_sad,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_mb_x,
    output logic [7:0]  res_mb_y,
    output logic [6:0]  res_mv_x,
    output logic [6:0]  res_mv_y,
    output logic [15:0] res_sad,
    output logic [23:0] frame_sad,
    output logic        err_timeout
);

    // Search radius: the unsigned offset that corresponds to a zero vector.
    localparam int MV_RADIUS = (SEARCH_DIM - MACRO_DIM) / 2;
    localparam int WD_W      = $clog2(TIMEOUT) + 1;

    localparam logic [7:0]      LAST_X  = 8'(FRAME_W_MB - 1);
    localparam logic [7:0]      LAST_Y  = 8'(FRAME_H_MB - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ARM  = 3'd2,
        S_RUN  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t          state_r;
    logic [WD_W-1:0] wdog_r;

    // Convert an unsigned search offset into a signed vector centred on zero.
    function automatic logic [6:0] centre_mv(input logic [5:0] mv);
        return {1'b0, mv} - 7'(MV_RADIUS);
    endfunction

    // Add a 16-bit SAD to the 24-bit frame total, clamping at all-ones.
    function automatic logic [23:0] sat_add24(input logic [23:0] acc,
                                              input logic [15:0] inc);
        logic [24:0] sum;
        sum = {1'b0, acc} + {9'd0, inc};
        return sum[24] ? 24'hFF_FFFF : sum[23:0];
    endfunction

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            wdog_r      <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            load_req    <= 1'b0;
            load_mb_x   <= 8'd0;
            load_mb_y   <= 8'd0;
            me_start    <= 1'b0;
            res_valid   <= 1'b0;
            res_mb_x    <= 8'd0;
            res_mb_y    <= 8'd0;
            res_mv_x    <= 7'd0;
            res_mv_y    <= 7'd0;
            res_sad     <= 16'd0;
            frame_sad   <= 24'd0;
            err_timeout <= 1'b0;
        end else begin
            // Pulse outputs default low; they are raised for one cycle only.
            me_start   <= 1'b0;
            frame_done <= 1'b0;

            case (state_r)
                S_IDLE: begin
                    if (frame_start) begin
                        state_r     <= S_LOAD;
                        busy        <= 1'b1;
                        load_req    <= 1'b1;
                        load_mb_x   <= 8'd0;
                        load_mb_y   <= 8'd0;
                        frame_sad   <= 24'd0;
                        err_timeout <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (load_done) begin
                        load_req <= 1'b0;
                        state_r  <= S_ARM;
                    end
                end

                S_ARM: begin
                    if (me_ready) begin
                        me_start <= 1'b1;
                        wdog_r   <= '0;
                        state_r  <= S_RUN;
                    end
                end

                S_RUN: begin
                    // A result arriving on the last watchdog cycle still wins.
                    if (me_valid) begin
                        res_valid <= 1'b1;
                        res_mb_x  <= load_mb_x;
                        res_mb_y  <= load_mb_y;
                        res_mv_x  <= centre_mv(me_mv_x);
                        res_mv_y  <= centre_mv(me_mv_y);
                        res_sad   <= me_min_sad;
                        state_r   <= S_OUT;
                    end else if (wdog_r == WD_LAST) begin
                        err_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        res_mb_x    <= load_mb_x;
                        res_mb_y    <= load_mb_y;
                        res_mv_x    <= 7'd0;
                        res_mv_y    <= 7'd0;
                        res_sad     <= 16'hFFFF;
                        state_r     <= S_OUT;
                    end else begin
                        wdog_r <= wdog_r + WD_W'(1);
                    end
                end

                S_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        frame_sad <= sat_add24(frame_sad, res_sad);
                        if ((load_mb_x == LAST_X) && (load_mb_y == LAST_Y)) begin
                            state_r    <= S_IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            if (load_mb_x == LAST_X) begin
                                load_mb_x <= 8'd0;
                                load_mb_y <= load_mb_y + 8'd1;
                            end else begin
                                load_mb_x <= load_mb_x + 8'd1;
                            end
                            load_req <= 1'b1;
                            state_r  <= S_LOAD;
                        end
                    end
                end

                default: begin
                    state_r   <= S_IDLE;
                    busy      <= 1'b0;
                    load_req  <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
